// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire neuron array:
// sweep FSM encoding, signed saturation and minimum-one width calculation.
package lif_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } lif_state_e;

  // Width of an index or counter, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  // Clamp a wide signed value into the range of a w-bit signed number.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational single-neuron step: leak, integrate, threshold and refractory.
// One instance is time-shared across every neuron of the array.
module lif_update
  import lif_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int V_THRESH   = 16384,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRACTORY = 10,
  parameter int RESET_MODE = 0,
  parameter int RW         = 4
) (
  input  logic signed [WIDTH-1:0] v_i,
  input  logic signed [WIDTH-1:0] acc_i,
  input  logic        [RW-1:0]    rc_i,
  output logic signed [WIDTH-1:0] v_o,
  output logic        [RW-1:0]    rc_o,
  output logic                    spike_o
);

  localparam int LS = (LEAK_SHIFT < 1)         ? 1 :
                      (LEAK_SHIFT > WIDTH - 1) ? WIDTH - 1 : LEAK_SHIFT;
  localparam logic signed [WIDTH-1:0] THR = WIDTH'(V_THRESH);

  logic signed [WIDTH+1:0] v_ext;
  logic signed [WIDTH+1:0] acc_ext;
  logic signed [WIDTH+1:0] sum;
  logic signed [63:0]      vn_wide;
  logic signed [WIDTH-1:0] vn;

  always_comb begin
    v_ext   = (WIDTH+2)'(v_i);
    acc_ext = (WIDTH+2)'(acc_i);
    // Two guard bits keep V + ACC - leak exact before clamping.
    sum     = v_ext + acc_ext - (v_ext >>> LS);
    vn_wide = saturate(64'(sum), WIDTH);
    vn      = vn_wide[WIDTH-1:0];

    v_o     = v_i;
    rc_o    = rc_i;
    spike_o = 1'b0;
    if (rc_i != '0) begin
      rc_o = rc_i - RW'(1);
    end else if (vn >= THR) begin
      spike_o = 1'b1;
      rc_o    = RW'(REFRACTORY);
      v_o     = (RESET_MODE == 1) ? (vn - THR) : '0;
    end else begin
      v_o = vn;
    end
  end

endmodule

// File: rtl/lif_array.sv
// Array of LIF neurons: events accumulate while idle, and each tick launches
// one sequential sweep that updates every neuron through a shared datapath.
module lif_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS  = 16,
  parameter int WIDTH      = 16,
  parameter int V_THRESH   = 16384,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRACTORY = 10,
  parameter int RESET_MODE = 0,
  localparam int IDX_W     = clog2_min1(N_NEURONS),
  localparam int RW        = clog2_min1(REFRACTORY + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  // Event handshake: an event transfers in any cycle where in_valid and
  // in_ready are both high; in_ready is high exactly while no sweep runs.
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IDX_W-1:0]        in_idx,
  input  logic signed [WIDTH-1:0] in_weight,
  input  logic                    tick,
  output logic                    busy,
  output logic                    sweep_done,
  output logic                    spike_valid,
  output logic [IDX_W-1:0]        spike_idx,
  output logic                    upd_valid,
  output logic [IDX_W-1:0]        upd_idx,
  output logic signed [WIDTH-1:0] upd_v
);

  lif_state_e state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic signed [WIDTH-1:0] v_q   [N_NEURONS];
  logic signed [WIDTH-1:0] acc_q [N_NEURONS];
  logic        [RW-1:0]    rc_q  [N_NEURONS];

  logic signed [WIDTH-1:0] v_new;
  logic        [RW-1:0]    rc_new;
  logic                    spike_new;

  logic                    sweep_last;
  logic                    accept;
  logic [31:0]             idx_ext;
  logic signed [WIDTH:0]   acc_sum;
  logic signed [63:0]      acc_wide;
  logic signed [WIDTH-1:0] acc_sat;

  logic                    upd_valid_q, upd_valid_d;
  logic [IDX_W-1:0]        upd_idx_q, upd_idx_d;
  logic signed [WIDTH-1:0] upd_v_q, upd_v_d;
  logic                    spike_valid_q, spike_valid_d;
  logic [IDX_W-1:0]        spike_idx_q, spike_idx_d;
  logic                    sweep_done_q, sweep_done_d;

  lif_update #(
    .WIDTH      (WIDTH),
    .V_THRESH   (V_THRESH),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRACTORY (REFRACTORY),
    .RESET_MODE (RESET_MODE),
    .RW         (RW)
  ) u_update (
    .v_i     (v_q[cnt_q]),
    .acc_i   (acc_q[cnt_q]),
    .rc_i    (rc_q[cnt_q]),
    .v_o     (v_new),
    .rc_o    (rc_new),
    .spike_o (spike_new)
  );

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_SWEEP);
  assign accept   = in_valid && in_ready;

  always_comb begin
    idx_ext  = 32'(in_idx);
    acc_sum  = (WIDTH+1)'(acc_q[in_idx]) + (WIDTH+1)'(in_weight);
    acc_wide = saturate(64'(acc_sum), WIDTH);
    acc_sat  = acc_wide[WIDTH-1:0];
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sweep_last    = (cnt_q == IDX_W'(N_NEURONS - 1));
    upd_valid_d   = 1'b0;
    upd_idx_d     = upd_idx_q;
    upd_v_d       = upd_v_q;
    spike_valid_d = 1'b0;
    spike_idx_d   = spike_idx_q;
    sweep_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      ST_SWEEP: begin
        upd_valid_d = 1'b1;
        upd_idx_d   = cnt_q;
        upd_v_d     = v_new;
        if (spike_new) begin
          spike_valid_d = 1'b1;
          spike_idx_d   = cnt_q;
        end
        cnt_d = cnt_q + IDX_W'(1);
        if (sweep_last) begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          sweep_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      upd_valid_q   <= 1'b0;
      upd_idx_q     <= '0;
      upd_v_q       <= '0;
      spike_valid_q <= 1'b0;
      spike_idx_q   <= '0;
      sweep_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      upd_valid_q   <= upd_valid_d;
      upd_idx_q     <= upd_idx_d;
      upd_v_q       <= upd_v_d;
      spike_valid_q <= spike_valid_d;
      spike_idx_q   <= spike_idx_d;
      sweep_done_q  <= sweep_done_d;
    end
  end

  // Sweep writes and event accumulation never overlap: events only land in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]   <= '0;
        acc_q[i] <= '0;
        rc_q[i]  <= '0;
      end
    end else if (state_q == ST_SWEEP) begin
      v_q[cnt_q]   <= v_new;
      rc_q[cnt_q]  <= rc_new;
      acc_q[cnt_q] <= '0;
    end else if (accept && (idx_ext < 32'(N_NEURONS))) begin
      acc_q[in_idx] <= acc_sat;
    end
  end

  assign upd_valid   = upd_valid_q;
  assign upd_idx     = upd_idx_q;
  assign upd_v       = upd_v_q;
  assign spike_valid = spike_valid_q;
  assign spike_idx   = spike_idx_q;
  assign sweep_done  = sweep_done_q;

endmodule

// File: tb/tb_lif_array.sv
// Bench for lif_array (4 neurons, threshold 1000, leak >>>4, refractory 2):
// directed scenarios plus randomized events against an integer neuron model.
module tb_lif_array;

  localparam int N    = 4;
  localparam int VT   = 1000;
  localparam int REFR = 2;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_idx;
  logic signed [15:0] in_weight;
  logic               tick;
  logic               busy;
  logic               sweep_done;
  logic               spike_valid;
  logic [1:0]         spike_idx;
  logic               upd_valid;
  logic [1:0]         upd_idx;
  logic signed [15:0] upd_v;

  int checks = 0;
  int errors = 0;

  // Reference model state, plain integers.
  int mv [N];
  int macc [N];
  int mrc [N];
  logic [15:0] exp_q [$];
  bit          sp_q [$];
  logic [15:0] obs_v [N];
  bit          obs_sp [N];

  lif_array #(
    .N_NEURONS  (N),
    .WIDTH      (16),
    .V_THRESH   (VT),
    .LEAK_SHIFT (4),
    .REFRACTORY (REFR),
    .RESET_MODE (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_idx      (in_idx),
    .in_weight   (in_weight),
    .tick        (tick),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .spike_valid (spike_valid),
    .spike_idx   (spike_idx),
    .upd_valid   (upd_valid),
    .upd_idx     (upd_idx),
    .upd_v       (upd_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp16(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0;
      macc[i] = 0;
      mrc[i] = 0;
    end
    exp_q.delete();
    sp_q.delete();
  endtask

  task automatic model_event(input int idx, input int w);
    if (idx < N) macc[idx] = clamp16(macc[idx] + w);
  endtask

  task automatic model_sweep();
    int vn;
    bit sp;
    for (int i = 0; i < N; i++) begin
      sp = 0;
      if (mrc[i] > 0) begin
        mrc[i] = mrc[i] - 1;
      end else begin
        // Leak is floor(V / 16), i.e. an arithmetic shift of a signed int.
        vn = clamp16(mv[i] + macc[i] - (mv[i] >>> 4));
        if (vn >= VT) begin
          sp = 1;
          mv[i] = 0;
          mrc[i] = REFR;
        end else begin
          mv[i] = vn;
        end
      end
      macc[i] = 0;
      exp_q.push_back(16'(mv[i]));
      sp_q.push_back(sp);
    end
  endtask

  task automatic send_event(input int idx, input int w);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ev_ready: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_idx = 2'(idx);
    in_weight = 16'(w);
    step();
    in_valid = 1'b0;
    model_event(idx, w);
  endtask

  // Tick (optionally with a coincident event), then check every cycle of the
  // sweep. noise adds a second tick and refused events while busy.
  task automatic do_sweep(input bit ev, input int eidx, input int ew, input bit noise);
    logic [15:0] e;
    bit es;
    tick = 1'b1;
    if (ev) begin
      in_valid = 1'b1;
      in_idx = 2'(eidx);
      in_weight = 16'(ew);
    end
    step();
    tick = 1'b0;
    in_valid = 1'b0;
    if (ev) model_event(eidx, ew);
    model_sweep();
    for (int k = 1; k <= N + 2; k++) begin
      checks++;
      if (busy !== (k <= N) || in_ready !== (k > N)) begin
        errors++;
        $display("FAIL sweep_busy k=%0d: busy=%b in_ready=%b required %b %b",
                 k, busy, in_ready, (k <= N), (k > N));
      end
      checks++;
      if (sweep_done !== (k == N + 1)) begin
        errors++;
        $display("FAIL sweep_done k=%0d: got %b required %b", k, sweep_done, (k == N + 1));
      end
      checks++;
      if (upd_valid !== (k >= 2 && k <= N + 1)) begin
        errors++;
        $display("FAIL upd_valid k=%0d: got %b", k, upd_valid);
      end
      if (k >= 2 && k <= N + 1) begin
        e = exp_q.pop_front();
        es = sp_q.pop_front();
        obs_v[k-2] = upd_v;
        obs_sp[k-2] = spike_valid;
        checks++;
        if (upd_idx !== 2'(k - 2) || upd_v !== e) begin
          errors++;
          $display("FAIL upd k=%0d: idx=%0d v=%0d required idx=%0d v=%0d",
                   k, upd_idx, upd_v, k - 2, $signed(e));
        end
        checks++;
        if (spike_valid !== es || (es && spike_idx !== 2'(k - 2))) begin
          errors++;
          $display("FAIL spike k=%0d: valid=%b idx=%0d required valid=%b idx=%0d",
                   k, spike_valid, spike_idx, es, k - 2);
        end
      end else begin
        checks++;
        if (spike_valid !== 1'b0) begin
          errors++;
          $display("FAIL spike_idle k=%0d: got %b required 0", k, spike_valid);
        end
      end
      if (noise && k == 1) tick = 1'b1;
      if (noise && k <= N) begin
        in_valid = 1'b1;
        in_idx = 2'd3;
        in_weight = 16'sd1234;
      end
      step();
      tick = 1'b0;
      in_valid = 1'b0;
    end
  endtask

  task automatic check_quiet(input string tag);
    checks++;
    if (busy !== 1'b0 || sweep_done !== 1'b0 || spike_valid !== 1'b0 ||
        upd_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b spk=%b upd=%b rdy=%b required 0 0 0 0 1",
               tag, busy, sweep_done, spike_valid, upd_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (busy !== 0 || sweep_done !== 0 || spike_valid !== 0 || upd_valid !== 0 ||
        spike_idx !== 0 || upd_idx !== 0 || upd_v !== 0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b spk=%b upd=%b sidx=%0d uidx=%0d v=%0d required all 0",
               busy, sweep_done, spike_valid, upd_valid, spike_idx, upd_idx, upd_v);
    end
    rst = 1'b0;
    model_reset();
    step();
    check_quiet("reset_ready");
    do_sweep(0, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs_v[i] !== 16'd0 || obs_sp[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_sweep n%0d: v=%0d spk=%b required 0 0", i, $signed(obs_v[i]), obs_sp[i]);
      end
    end
  endtask

  task automatic test_integrate();
    send_event(2, 600);
    do_sweep(0, 0, 0, 0);
    checks++;
    if (obs_v[2] !== 16'd600) begin
      errors++;
      $display("FAIL integ_600: v=%0d required 600", $signed(obs_v[2]));
    end
    send_event(2, 600);
    do_sweep(0, 0, 0, 0);
    checks++;
    if (obs_sp[2] !== 1'b1 || obs_v[2] !== 16'd0) begin
      errors++;
      $display("FAIL integ_spike: spk=%b v=%0d required 1 0", obs_sp[2], $signed(obs_v[2]));
    end
  endtask

  task automatic test_refractory();
    for (int r = 0; r < 2; r++) begin
      send_event(2, 2000);
      do_sweep(0, 0, 0, 0);
      checks++;
      if (obs_sp[2] !== 1'b0 || obs_v[2] !== 16'd0) begin
        errors++;
        $display("FAIL refr_hold%0d: spk=%b v=%0d required 0 0", r, obs_sp[2], $signed(obs_v[2]));
      end
    end
    send_event(2, 2000);
    do_sweep(0, 0, 0, 0);
    checks++;
    if (obs_sp[2] !== 1'b1) begin
      errors++;
      $display("FAIL refr_release: spk=%b required 1", obs_sp[2]);
    end
  endtask

  task automatic test_saturation();
    for (int r = 0; r < 2; r++) begin
      send_event(0, -30000);
      send_event(0, -30000);
      do_sweep(0, 0, 0, 0);
      checks++;
      if (obs_v[0] !== 16'h8000 || obs_sp[0] !== 1'b0) begin
        errors++;
        $display("FAIL sat_%0d: v=%0d spk=%b required -32768 0", r, $signed(obs_v[0]), obs_sp[0]);
      end
    end
  endtask

  task automatic test_handshake();
    // Coincident event is counted; tick and events during the sweep are not.
    do_sweep(1, 1, 900, 1);
    checks++;
    if (obs_v[1] !== 16'd900) begin
      errors++;
      $display("FAIL hs_coincident: v=%0d required 900", $signed(obs_v[1]));
    end
    check_quiet("hs_no_requeue");
    do_sweep(0, 0, 0, 0);
    checks++;
    if (obs_v[3] !== exp_q.size() + 16'(mv[3])) begin
      errors++;
      $display("FAIL hs_refused_events: v3=%0d required %0d", $signed(obs_v[3]), mv[3]);
    end
  endtask

  task automatic test_random();
    int nev;
    for (int r = 0; r < 12; r++) begin
      nev = $urandom_range(0, 4);
      for (int e = 0; e < nev; e++)
        send_event($urandom_range(0, N - 1), int'($urandom_range(0, 4000)) - 1500);
      do_sweep($urandom_range(0, 1), $urandom_range(0, N - 1),
               int'($urandom_range(0, 3000)) - 1000, $urandom_range(0, 1));
    end
  endtask

  task automatic test_abort();
    send_event(1, 700);
    send_event(3, 1500);
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (upd_valid !== 0 || busy !== 0 || sweep_done !== 0 || spike_valid !== 0) begin
      errors++;
      $display("FAIL abort_now: upd=%b busy=%b done=%b spk=%b required 0",
               upd_valid, busy, sweep_done, spike_valid);
    end
    step();
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      check_quiet("abort_quiet");
      step();
    end
    do_sweep(0, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs_v[i] !== 16'd0 || obs_sp[i] !== 1'b0) begin
        errors++;
        $display("FAIL abort_clean n%0d: v=%0d spk=%b required 0 0", i, $signed(obs_v[i]), obs_sp[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_idx = '0;
    in_weight = '0;
    tick = 1'b0;
    model_reset();
    #2;
    test_reset();
    test_integrate();
    test_refractory();
    test_saturation();
    test_handshake();
    test_random();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lif_array.md
LIF_ARRAY -- requirements
Module: lif_array

Interface
REQ-001 Parameter N_NEURONS, default 16: neuron count, SHALL be >= 2.
REQ-002 Parameter WIDTH, default 16: signed bit-width of membrane potential, weight and accumulator.
REQ-003 Parameter V_THRESH, default 16384: spiking threshold; SHALL satisfy 0 < V_THRESH <= 2^(WIDTH-1)-1.
REQ-004 Parameter LEAK_SHIFT, default 4: arithmetic right-shift giving the leak; an out-of-range value SHALL be clamped to 1..WIDTH-1.
REQ-005 Parameter REFRACTORY, default 10: refractory period, counted in ticks.
REQ-006 Parameter RESET_MODE, default 0: 0 = reset to zero on spike, 1 = subtract V_THRESH on spike.
REQ-007 Derived: IDX_W = max(1, clog2(N_NEURONS)); RW = max(1, clog2(REFRACTORY+1)).
REQ-008 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-009 Ports (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  synaptic event valid.
- in_ready  out  1  event accept.
- in_idx  in  IDX_W  target neuron.
- in_weight  in  WIDTH signed  event weight.
- tick  in  1  timestep strobe.
- busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle end-of-sweep pulse.
- spike_valid  out  1  spike event.
- spike_idx  out  IDX_W  spiking neuron.
- upd_valid  out  1  neuron-update monitor strobe.
- upd_idx  out  IDX_W  updated neuron.
- upd_v  out  WIDTH signed  new membrane potential.

Function
REQ-010 Per-neuron state SHALL be: V (WIDTH signed), synaptic accumulator ACC (WIDTH signed), refractory counter RC (RW bits).
REQ-011 The FSM SHALL have two states: IDLE and SWEEP.
- IDLE -> SWEEP on tick.
- SWEEP -> IDLE after neuron N_NEURONS-1 is updated.
REQ-012 Input handshake:
- in_ready = (state==IDLE).
- An event is accepted when in_valid && in_ready; ACC[in_idx] <= sat(ACC[in_idx] + in_weight).
- in_idx >= N_NEURONS SHALL be accepted and discarded.
REQ-013 An event accepted in the same cycle as the starting tick SHALL be included in that sweep.
REQ-014 A tick seen during SWEEP SHALL be ignored, with no queueing.
REQ-015 Timing: for a tick in IDLE at cycle t:
- Neuron i is updated at the clock edge ending cycle t+1+i.
- busy is high for cycles t+1..t+N_NEURONS.
REQ-016 Update when RC>0: RC <= RC-1; V unchanged; ACC <= 0 (input discarded); no spike.
REQ-017 Update when RC==0:
- Vn = sat(V + ACC - (V >>> LEAK_SHIFT)), computed at WIDTH+2 bits and saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- ACC <= 0.
REQ-018 Spike condition: if Vn >= V_THRESH, spike; V <= 0 (RESET_MODE 0) or Vn - V_THRESH (RESET_MODE 1); RC <= REFRACTORY. Otherwise V <= Vn.
REQ-019 Outputs are registered; for neuron i they are visible in cycle t+2+i:
- upd_valid=1, upd_idx=i, upd_v = new V.
- spike_valid and spike_idx are set if neuron i spiked.
REQ-020 Strobes are one cycle wide:
- sweep_done pulses in cycle t+N_NEURONS+1.
- spike_valid, upd_valid and sweep_done are 0 at all other times.
REQ-021 Output ports have no backpressure; at most one spike is output per cycle.

Reset
REQ-022 On rst:
- All V, ACC and RC are cleared to 0 and the FSM goes to IDLE.
- busy, sweep_done, spike_valid and upd_valid go to 0; spike_idx, upd_idx and upd_v go to 0.
- in_ready is 1 after rst is released.
REQ-023 rst asserted mid-sweep SHALL abort the sweep with no further spike or upd strobes, and SHALL discard in-flight state.

Structure
REQ-024 Package lif_pkg SHALL hold the FSM state enum, the saturate function and the derived-width helper.
REQ-025 Sub-module lif_update SHALL be combinational: (V, ACC, RC) -> (V', RC', spike), so one datapath is shared across all neurons.
REQ-026 State SHALL be held in arrays indexed by a sweep counter; the sweep counter and FSM reside in lif_array.

Verification (N_NEURONS=4, WIDTH=16, V_THRESH=1000, LEAK_SHIFT=4, REFRACTORY=2)
REQ-027 Reset: rst pulse -> all outputs 0, in_ready=1; tick -> upd_v=0 for idx 0..3, and no spikes.
REQ-028 Integration and spike:
- Event (2, 600), then tick -> upd_v[2]=600.
- Event (2, 600), then tick -> 600+600-37 = 1163 -> spike_idx=2, upd_v=0 (RESET_MODE 0) or 163 (RESET_MODE 1).
REQ-029 Refractory: after the REQ-028 spike, event (2, 2000) before each of the next 2 ticks -> no spike and V stays; event (2, 2000) plus a 3rd tick -> spike_idx=2.
REQ-030 Saturation:
- Events (0, -30000) x2 -> ACC=-32768.
- tick -> upd_v=-32768.
- Repeat -> -32768 (no wrap), no spike.
REQ-031 Handshake and timing:
- tick and in_valid in the same cycle -> the event is counted.
- in_ready=0 and busy=1 for exactly 4 cycles.
- A second tick during the sweep is ignored.
- sweep_done occurs exactly 5 cycles after the tick.
REQ-032 Abort: rst in the 2nd sweep cycle -> no further upd_valid or sweep_done, all V=0, and a subsequent tick behaves as after power-up.
